// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : types and constants shared by the fetch-side core blocks
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DROP = 2'd3
   } ic_req_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/core_fetch_queue.sv
// ============================================================================
// core_fetch_queue : DEPTH-entry synchronous FIFO of {pc, instr} for decode
// Revision         : 1.0
// ============================================================================
`default_nettype none

module core_fetch_queue
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  fetch_entry_t               push_data_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       head_val_o,
   output fetch_entry_t               head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;

   logic            do_push;
   logic            do_pop;

   // A clear wins over any same-cycle push or pop.
   assign do_push = push_i & ~clear_i;
   assign do_pop  = pop_i & (count_q != '0) & ~clear_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o    = count_q;
   assign head_val_o = (count_q != '0);
   assign head_o     = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/core_if_ic_req.sv
// ============================================================================
// core_if_ic_req : single-outstanding I-cache request stage feeding decode
// Revision       : 1.0
// ============================================================================
`default_nettype none

module core_if_ic_req #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic        if_redirect,
   output logic        if_pc_stop,
   output logic        ic_req_val,
   output logic [31:0] ic_req_addr,
   input  logic        ic_req_ack,
   input  logic        ic_resp_val,
   input  logic [31:0] ic_resp_data,
   input  logic        id_stall,
   output logic        id_val,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_4,
   output logic [31:0] id_instr
);

   import core_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   ic_req_state_t  state_q;
   ic_req_state_t  state_d;
   logic [31:0]    req_addr_q;
   logic [31:0]    req_addr_d;
   logic           req_val_q;

   logic           capture;
   logic           push;
   logic           pop;
   logic [CW-1:0]  count;
   logic           head_val;
   fetch_entry_t   head;
   fetch_entry_t   push_entry;

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      capture    = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!if_redirect && (count < CW'(DEPTH))) begin
               capture    = 1'b1;
               req_addr_d = if_pc;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            // An un-acked request may simply be withdrawn on redirect.
            if (if_redirect) begin
               state_d = ic_req_ack ? S_DROP : S_IDLE;
            end else if (ic_req_ack) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (ic_resp_val) begin
               push    = ~if_redirect;
               state_d = S_IDLE;
            end else if (if_redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (ic_resp_val) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         req_addr_q <= '0;
         req_val_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         req_val_q  <= (state_d == S_REQ);
      end
   end

   assign if_pc_stop  = ~(capture | if_redirect);
   assign ic_req_val  = req_val_q;
   assign ic_req_addr = word_align(req_addr_q);

   assign push_entry.pc    = req_addr_q;
   assign push_entry.instr = ic_resp_data;
   assign pop              = head_val & ~id_stall;

   core_fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .clear_i     (if_redirect),
      .count_o     (count),
      .head_val_o  (head_val),
      .head_o      (head)
   );

   // Empty queue presents a clean NOP at PC 0 to decode.
   assign id_val   = head_val;
   assign id_pc    = head_val ? head.pc : 32'h0;
   assign id_pc_4  = id_pc + 32'd4;
   assign id_instr = head_val ? head.instr : NOP_INSTR;

endmodule

`default_nettype wire

// File: tb/tb_core_if_ic_req.sv
// ============================================================================
// tb_core_if_ic_req : directed self-checking bench for core_if_ic_req
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_core_if_ic_req;

   localparam logic [31:0] C_NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_pc = 32'h0000_0200;
   logic        if_redirect = 1'b0;
   logic        if_pc_stop;
   logic        ic_req_val;
   logic [31:0] ic_req_addr;
   logic        ic_req_ack = 1'b0;
   logic        ic_resp_val = 1'b0;
   logic [31:0] ic_resp_data = 32'h0;
   logic        id_stall = 1'b0;
   logic        id_val;
   logic [31:0] id_pc;
   logic [31:0] id_pc_4;
   logic [31:0] id_instr;

   logic [31:0] redir_tgt = 32'h0;
   int          errors = 0;
   int          checks = 0;

   core_if_ic_req #(
      .DEPTH     (2),
      .NOP_INSTR (C_NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_pc        (if_pc),
      .if_redirect  (if_redirect),
      .if_pc_stop   (if_pc_stop),
      .ic_req_val   (ic_req_val),
      .ic_req_addr  (ic_req_addr),
      .ic_req_ack   (ic_req_ack),
      .ic_resp_val  (ic_resp_val),
      .ic_resp_data (ic_resp_data),
      .id_stall     (id_stall),
      .id_val       (id_val),
      .id_pc        (id_pc),
      .id_pc_4      (id_pc_4),
      .id_instr     (id_instr)
   );

   always #5 clk = ~clk;

   // PC register: loads the redirect target, otherwise advances unless held.
   always @(posedge clk) begin
      if (!rst) begin
         if (if_redirect)      if_pc <= redir_tgt;
         else if (!if_pc_stop) if_pc <= if_pc + 32'd4;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_val"},  {31'h0, ic_req_val}, 32'h0);
      check({tag, "_req_addr"}, ic_req_addr,         32'h0);
      check({tag, "_id_val"},   {31'h0, id_val},     32'h0);
      check({tag, "_id_pc"},    id_pc,               32'h0);
      check({tag, "_id_pc_4"},  id_pc_4,             32'h4);
      check({tag, "_id_instr"}, id_instr,            C_NOP);
      check({tag, "_pc_stop"},  {31'h0, if_pc_stop}, 32'h0);
   endtask

   // Wait (bounded) for a request, check its address, ack it and respond next cycle.
   task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
      int n = 0;
      while (!ic_req_val && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req_seen"}, {31'h0, ic_req_val}, 32'h1);
      check({tag, "_req_addr"}, ic_req_addr, exp_addr);
      ic_req_ack = 1'b1;
      tick();
      ic_req_ack   = 1'b0;
      ic_resp_val  = 1'b1;
      ic_resp_data = data;
      tick();
      ic_resp_val  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset ----------------
      #1 rst = 1'b1;
      tick();
      tick();
      check_reset_outputs("rst");
      rst = 1'b0;

      // ---------------- sequential fetch ----------------
      fetch("f0", 32'h200, 32'h1111_0001);
      check("f0_id_val",   {31'h0, id_val}, 32'h1);
      check("f0_id_pc",    id_pc,    32'h200);
      check("f0_id_pc_4",  id_pc_4,  32'h204);
      check("f0_id_instr", id_instr, 32'h1111_0001);
      fetch("f1", 32'h204, 32'h1111_0002);
      check("f1_id_pc",    id_pc,    32'h204);
      check("f1_id_instr", id_instr, 32'h1111_0002);

      // ---------------- stall fills the queue ----------------
      id_stall = 1'b1;
      fetch("f2", 32'h208, 32'h1111_0003);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("full_req_val", {31'h0, ic_req_val}, 32'h0);
         check("full_pc_stop", {31'h0, if_pc_stop}, 32'h1);
      end
      check("full_id_pc", id_pc, 32'h204);
      id_stall = 1'b0;
      tick();
      check("rel_id_pc",    id_pc,    32'h208);
      check("rel_id_instr", id_instr, 32'h1111_0003);
      check("rel_pc_stop",  {31'h0, if_pc_stop}, 32'h0);
      fetch("f3", 32'h20C, 32'h1111_0004);
      check("f3_id_pc", id_pc, 32'h20C);

      // ---------------- redirect in S_RESP ----------------
      tick();
      check("rr_req_addr", ic_req_addr, 32'h210);
      ic_req_ack = 1'b1;
      tick();
      ic_req_ack  = 1'b0;
      redir_tgt   = 32'h400;
      if_redirect = 1'b1;
      #1;
      check("rr_pc_stop", {31'h0, if_pc_stop}, 32'h0);
      tick();
      if_redirect = 1'b0;
      tick();
      check("rr_drop_req_val", {31'h0, ic_req_val}, 32'h0);
      tick();
      ic_resp_val  = 1'b1;
      ic_resp_data = 32'hDEAD_BEEF;
      tick();
      ic_resp_val  = 1'b0;
      check("rr_id_val", {31'h0, id_val}, 32'h0);
      fetch("f4", 32'h400, 32'h2222_0001);
      check("f4_id_pc",    id_pc,    32'h400);
      check("f4_id_instr", id_instr, 32'h2222_0001);

      // ---------------- redirect in S_REQ, no ack ----------------
      tick();
      check("rq_req_addr", ic_req_addr, 32'h404);
      redir_tgt   = 32'h500;
      if_redirect = 1'b1;
      tick();
      if_redirect = 1'b0;
      check("rq_req_val", {31'h0, ic_req_val}, 32'h0);
      check("rq_id_val",  {31'h0, id_val},     32'h0);
      fetch("f5", 32'h500, 32'h3333_0001);

      // ---------------- push+pop same cycle, full queue, redirect ----------------
      id_stall = 1'b1;
      tick();
      check("pp_req_addr", ic_req_addr, 32'h504);
      ic_req_ack = 1'b1;
      tick();
      ic_req_ack   = 1'b0;
      ic_resp_val  = 1'b1;
      ic_resp_data = 32'h3333_0002;
      id_stall     = 1'b0;
      tick();
      ic_resp_val  = 1'b0;
      id_stall     = 1'b1;
      check("pp_id_val",   {31'h0, id_val}, 32'h1);
      check("pp_id_pc",    id_pc,    32'h504);
      check("pp_id_instr", id_instr, 32'h3333_0002);
      fetch("f6", 32'h508, 32'h3333_0003);
      check("fq_pc_stop", {31'h0, if_pc_stop}, 32'h1);
      check("fq_id_pc",   id_pc, 32'h504);
      id_stall = 1'b0;
      tick();
      check("fq_pop_id_pc", id_pc, 32'h508);
      id_stall    = 1'b1;
      redir_tgt   = 32'h600;
      if_redirect = 1'b1;
      tick();
      if_redirect = 1'b0;
      check("fq_clr_id_val",   {31'h0, id_val}, 32'h0);
      check("fq_clr_id_instr", id_instr, C_NOP);
      id_stall = 1'b0;
      tick();
      check("fq_req_addr", ic_req_addr, 32'h600);

      // ---------------- reset while in S_DROP ----------------
      ic_req_ack = 1'b1;
      tick();
      ic_req_ack  = 1'b0;
      redir_tgt   = 32'h700;
      if_redirect = 1'b1;
      tick();
      if_redirect = 1'b0;
      check("dr_req_val", {31'h0, ic_req_val}, 32'h0);
      rst = 1'b1;
      #1;
      check_reset_outputs("arst");
      tick();
      rst = 1'b0;
      tick();
      check("arst_req_addr", ic_req_addr, 32'h700);
      fetch("f7", 32'h700, 32'h4444_0001);
      check("f7_id_pc",   id_pc,   32'h700);
      check("f7_id_pc_4", id_pc_4, 32'h704);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
